// File: rtl/mdl_pgcmp_mc_if.sv
// mdl_pgcmp_mc_if -- bundle of the bit-serial page comparator's stream and
// result signals.
//   i_CLK2M_PCEN_n   bit-step enable, active-low
//   i_FRAME_START    frame start strobe
//   i_PGREG_LSB      per-channel serial relative page, LSB first
//   i_ABSPGCNTR_LSB  shared serial absolute page counter, LSB first
//   i_CONV_EN        per-channel relative->absolute conversion enable
//   i_UMODE_n        user mode, active-low (1 forces all results to 0)
//   o_PGCMP_EQ       per-channel page-equal flags
//   o_MATCH_VALID    one-cycle pulse when o_PGCMP_EQ is updated
//   o_BUSY           frame in progress
//   o_OVRUN          sticky: frame start seen while busy
// master = stream source, slave = comparator.
interface mdl_pgcmp_mc_if #(
    parameter int NCH = 2
);
    logic           i_CLK2M_PCEN_n;
    logic           i_FRAME_START;
    logic [NCH-1:0] i_PGREG_LSB;
    logic           i_ABSPGCNTR_LSB;
    logic [NCH-1:0] i_CONV_EN;
    logic           i_UMODE_n;
    logic [NCH-1:0] o_PGCMP_EQ;
    logic           o_MATCH_VALID;
    logic           o_BUSY;
    logic           o_OVRUN;

    modport master (
        output i_CLK2M_PCEN_n, i_FRAME_START, i_PGREG_LSB, i_ABSPGCNTR_LSB,
               i_CONV_EN, i_UMODE_n,
        input  o_PGCMP_EQ, o_MATCH_VALID, o_BUSY, o_OVRUN
    );

    modport slave (
        input  i_CLK2M_PCEN_n, i_FRAME_START, i_PGREG_LSB, i_ABSPGCNTR_LSB,
               i_CONV_EN, i_UMODE_n,
        output o_PGCMP_EQ, o_MATCH_VALID, o_BUSY, o_OVRUN
    );
endinterface

// File: rtl/mdl_pgcmp_mc.sv
// mdl_pgcmp_mc -- multi-channel bit-serial page comparator.
// Each frame the relative page of every channel is streamed twice, LSB first.
// Pass 1 (EVAL) only finds whether rel >= OFFSET. Pass 2 (CMP) converts rel
// to an absolute page (rel-OFFSET, or rel+PGCNT-OFFSET when it wrapped) and
// compares it bit by bit against the shared absolute page counter stream.
// Ports:
//   i_MCLK  master clock, rising edge
//   i_RST   asynchronous active-high reset
//   bus     mdl_pgcmp_mc_if.slave (stream inputs, result outputs)

// One comparator channel: eval carry, gte flag, two conversion adders and the
// sticky mismatch bit.
module mdl_pgcmp_mc_lane #(
    parameter bit OFS_ZERO = 1'b0
) (
    input  logic i_MCLK,
    input  logic i_RST,
    input  logic eval_stb,   // enabled edge processing an EVAL bit
    input  logic cmp_stb,    // enabled edge processing a CMP bit
    input  logic first,      // bit 0 of the current pass
    input  logic last,       // bit PGW-1 of the current pass
    input  logic rel_b,
    input  logic abs_b,
    input  logic conv,
    input  logic k1_b,       // bit of (2^PGW - OFFSET)
    input  logic k2_b,       // bit of (PGCNT - OFFSET)
    output logic gte,
    output logic mismatch
);
    logic c_eval, c_sub, c_add;
    logic ci_e, ci_s, ci_a;
    logic co_e, co_s, co_a;
    logic sum_s, sum_a, tgt;

    // Carries start from zero on bit 0 of each pass.
    assign ci_e = c_eval & ~first;
    assign ci_s = c_sub  & ~first;
    assign ci_a = c_add  & ~first;

    assign co_e  = (rel_b & k1_b) | (ci_e & (rel_b ^ k1_b));
    // rel - OFFSET is rel + (2^PGW - OFFSET) modulo 2^PGW.
    assign sum_s = rel_b ^ k1_b ^ ci_s;
    assign co_s  = (rel_b & k1_b) | (ci_s & (rel_b ^ k1_b));
    assign sum_a = rel_b ^ k2_b ^ ci_a;
    assign co_a  = (rel_b & k2_b) | (ci_a & (rel_b ^ k2_b));

    assign tgt = conv ? (gte ? sum_s : sum_a) : rel_b;

    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            c_eval   <= 1'b0;
            c_sub    <= 1'b0;
            c_add    <= 1'b0;
            gte      <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            if (eval_stb) begin
                c_eval <= co_e;
                // Carry out of rel + (2^PGW - OFFSET) is rel >= OFFSET;
                // with OFFSET = 0 the constant is 0 and the test is trivially true.
                if (last)
                    gte <= co_e | OFS_ZERO;
            end
            if (cmp_stb) begin
                c_sub    <= co_s;
                c_add    <= co_a;
                mismatch <= (mismatch & ~first) | (tgt ^ abs_b);
            end
        end
    end
endmodule

module mdl_pgcmp_mc #(
    parameter int PGW    = 12,
    parameter int PGCNT  = 2053,
    parameter int OFFSET = 1299,
    parameter int NCH    = 2
) (
    input  logic          i_MCLK,
    input  logic          i_RST,
    mdl_pgcmp_mc_if.slave bus
);
    localparam int CW = (PGW > 1) ? $clog2(PGW) : 1;
    localparam logic [PGW-1:0] K1 = PGW'((2 ** PGW) - OFFSET);
    localparam logic [PGW-1:0] K2 = PGW'(PGCNT - OFFSET);
    localparam bit OFS_ZERO = (OFFSET == 0);

    typedef enum logic [1:0] {IDLE, EVAL, CMP, DONE} st_t;

    st_t            st;
    logic [CW-1:0]  bit_cnt;
    logic [NCH-1:0] eq_q, mm, gte;
    logic           vld_q, busy_q, ovr_q;

    logic en, eval_stb, cmp_stb, first, last;

    assign en       = ~bus.i_CLK2M_PCEN_n;
    // The frame-start edge itself already processes EVAL bit 0.
    assign eval_stb = en & (((st == IDLE) & bus.i_FRAME_START) | (st == EVAL));
    assign cmp_stb  = en & (st == CMP);
    assign first    = (bit_cnt == '0);
    assign last     = (bit_cnt == CW'(PGW - 1));

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        mdl_pgcmp_mc_lane #(.OFS_ZERO(OFS_ZERO)) u_lane (
            .i_MCLK   (i_MCLK),
            .i_RST    (i_RST),
            .eval_stb (eval_stb),
            .cmp_stb  (cmp_stb),
            .first    (first),
            .last     (last),
            .rel_b    (bus.i_PGREG_LSB[g]),
            .abs_b    (bus.i_ABSPGCNTR_LSB),
            .conv     (bus.i_CONV_EN[g]),
            .k1_b     (K1[bit_cnt]),
            .k2_b     (K2[bit_cnt]),
            .gte      (gte[g]),
            .mismatch (mm[g])
        );
    end

    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            st      <= IDLE;
            bit_cnt <= '0;
            eq_q    <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            // Pulse lasts one MCLK regardless of the bit-step enable.
            vld_q <= 1'b0;
            if (en) begin
                if ((st != IDLE) && bus.i_FRAME_START)
                    ovr_q <= 1'b1;
                case (st)
                    IDLE: begin
                        if (bus.i_FRAME_START) begin
                            st      <= EVAL;
                            busy_q  <= 1'b1;
                            bit_cnt <= CW'(1);
                        end
                    end
                    EVAL: begin
                        if (last) begin
                            st      <= CMP;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    CMP: begin
                        if (last) begin
                            st      <= DONE;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    DONE: begin
                        eq_q   <= bus.i_UMODE_n ? '0 : ~mm;
                        vld_q  <= 1'b1;
                        busy_q <= 1'b0;
                        st     <= IDLE;
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

    assign bus.o_PGCMP_EQ    = eq_q;
    assign bus.o_MATCH_VALID = vld_q;
    assign bus.o_BUSY        = busy_q;
    assign bus.o_OVRUN       = ovr_q;
endmodule

// File: doc/mdl_pgcmp_mc.md
MDL_PGCMP_MC -- requirements
Module: mdl_pgcmp_mc

Interface
REQ-001 Parameter PGW, default 12: width of the page numbers, in bits.
REQ-002 Parameter PGCNT, default 2053: number of pages in one loop.
REQ-003 Parameter OFFSET, default 1299: the relative page number that maps to absolute page 0. OFFSET SHALL be less than PGCNT.
REQ-004 Parameter NCH, default 2: number of independent comparator channels.
REQ-005 i_MCLK  input  1  master clock; all state is updated on the rising edge.
REQ-006 i_RST  input  1  reset, asynchronous and active-high.
REQ-007 i_CLK2M_PCEN_n  input  1  bit-step clock enable, active-low; state advances only on MCLK edges where this is 0.
REQ-008 i_FRAME_START  input  1  starts a frame; sampled on enabled edges.
REQ-009 i_PGREG_LSB  input  NCH  serial relative page bit for each channel, LSB first.
REQ-010 i_ABSPGCNTR_LSB  input  1  serial absolute page counter bit, LSB first, shared by all channels.
REQ-011 i_CONV_EN  input  NCH  per channel: 1 = convert relative page to absolute page; 0 = compare the raw value.
REQ-012 i_UMODE_n  input  1  user mode flag, active-low.
REQ-013 o_PGCMP_EQ  output  NCH  per-channel page-equal flag.
REQ-014 o_MATCH_VALID  output  1  one-MCLK pulse indicating that o_PGCMP_EQ has been updated.
REQ-015 o_BUSY  output  1  a frame is in progress.
REQ-016 o_OVRUN  output  1  sticky flag: a frame start arrived while busy.

Function
REQ-017 FSM states: IDLE, EVAL, CMP, DONE. All transitions occur only on enabled edges.
REQ-018 IDLE: i_FRAME_START=1 → EVAL. Bit counter = 0. Bit 0 is sampled on the same enabled edge.
REQ-019 EVAL lasts PGW enabled edges. On each edge, every channel serially computes rel + (2^PGW − OFFSET) using a 1-bit carry register. The carry is cleared at frame start.
REQ-020 On the last EVAL bit, the final carry is latched per channel as gte[c] (rel ≥ OFFSET). The FSM then goes to CMP and the bit counter returns to 0.
REQ-021 During CMP, the source re-presents the same PGW bits, LSB first. This phase lasts PGW enabled edges.
REQ-022 CMP carries: an independent sub carry and add carry per channel, both cleared at CMP bit 0.
REQ-023 Target bit per channel:
- i_CONV_EN[c]=0 → raw i_PGREG_LSB[c].
- i_CONV_EN[c]=1 and gte[c]=1 → serial sum of rel − OFFSET.
- i_CONV_EN[c]=1 and gte[c]=0 → serial sum of rel + (PGCNT − OFFSET).
REQ-024 Arithmetic is modulo 2^PGW. Carries out of bit PGW−1 are discarded.
REQ-025 A per-channel sticky mismatch bit is cleared at CMP bit 0. It ORs in (target XOR i_ABSPGCNTR_LSB) on every CMP bit.
REQ-026 After the last CMP bit → DONE. On that DONE edge: o_PGCMP_EQ[c] = ~mismatch[c], or 0 for all channels if i_UMODE_n=1. o_MATCH_VALID pulses high for exactly one MCLK cycle. The FSM then goes to IDLE.
REQ-027 o_PGCMP_EQ holds its value between DONE edges. i_CONV_EN and i_UMODE_n are sampled only where specified above.
REQ-028 Latency: the result is valid 2·PGW+1 enabled edges after the frame-start edge.
REQ-029 o_BUSY = 1 in EVAL, CMP and DONE.
REQ-030 An i_FRAME_START while not IDLE is ignored (the frame is not restarted) and sets o_OVRUN.
REQ-031 An i_FRAME_START on the DONE edge is also ignored.
REQ-032 Relative pages ≥ PGCNT are not flagged. They are converted by the gte=1 rule.
REQ-033 Edges with i_CLK2M_PCEN_n=1 change no state. o_MATCH_VALID still deasserts after one MCLK cycle.

Reset
REQ-034 i_RST=1 immediately forces: FSM IDLE, bit counter 0, all carries 0, gte 0, mismatch 0, o_PGCMP_EQ 0, o_MATCH_VALID 0, o_BUSY 0, o_OVRUN 0.
REQ-035 A reset mid-frame abandons the frame. No o_MATCH_VALID is generated for it.
REQ-036 After reset release, the first enabled edge with i_FRAME_START=1 starts a fresh frame.

Verification (defaults PGW=12, PGCNT=2053, OFFSET=1299, NCH=2)
REQ-037 ch0 rel=1296, conv=1; abs stream=2050 → EQ[0]=1. ch1 rel=1296, conv=1; abs=2049 → EQ[1]=0. Both update on the same o_MATCH_VALID pulse.
REQ-038 rel=1299 vs abs=0 → EQ=1. rel=2052 vs abs=753 → EQ=1. rel=1298 vs abs=2052 → EQ=1.
REQ-039 conv=0, rel=abs=1299 → EQ=1. conv=0, rel=1299, abs=0 → EQ=0.
REQ-040 i_UMODE_n=1 with matching data → EQ=00 and o_MATCH_VALID still pulses.
REQ-041 A second i_FRAME_START during CMP → o_OVRUN=1 and the frame completes with the original result. Random i_CLK2M_PCEN_n gaps do not change the result.
REQ-042 Assert i_RST at CMP bit 5 → all outputs 0 immediately and no pulse. A new frame then produces the correct result.
